// File: rtl/ysyx_25030093_lsu_pkg.sv
// Shared types and constants for the ysyx_25030093 load/store unit.
// Includes the misalignment classifier used when YSYX_25030093_LSU_MISALIGN_TRAP_EN is defined.
package ysyx_25030093_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_WB   = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Store codes share the load size encoding, so one classifier serves both.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        case (funct3)
            F3_LB, F3_LBU: mis = 1'b0;
            F3_LH, F3_LHU: mis = off[0];
            default:       mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_fmt.sv
// Combinational data formatter: load byte/halfword extraction with extension,
// and store byte-lane replication with write-strobe generation.
module ysyx_25030093_lsu_fmt
    import ysyx_25030093_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] sdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] ldata,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wmask
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword out of the raw read word.
    always_comb begin
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Sign or zero extend according to the load width code.
    always_comb begin
        case (funct3)
            F3_LB:   ldata = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
            F3_LBU:  ldata = {{(DATA_WIDTH-8){1'b0}}, byte_s};
            F3_LH:   ldata = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
            F3_LHU:  ldata = {{(DATA_WIDTH-16){1'b0}}, half_s};
            F3_LW:   ldata = rdata;
            default: ldata = rdata;
        endcase
    end

    // Replicate store data across all lanes; the strobe picks the live ones.
    always_comb begin
        case (funct3)
            F3_SB: begin
                wmask = MASK_B << offset;
                wdata = {(DATA_WIDTH/8){sdata[7:0]}};
            end
            F3_SH: begin
                wmask = MASK_H << offset;
                wdata = {(DATA_WIDTH/16){sdata[15:0]}};
            end
            F3_SW: begin
                wmask = MASK_W;
                wdata = sdata;
            end
            default: begin
                wmask = MASK_W;
                wdata = sdata;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25030093_lsu.sv
// Load/store unit: single-outstanding memory bus master plus GPR write-back handshake.
// Optional misaligned-access trap enabled by defining YSYX_25030093_LSU_MISALIGN_TRAP_EN.
module ysyx_25030093_lsu
    import ysyx_25030093_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_sdata,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_wdata,
    output logic [ADDR_WIDTH-1:0] wb_waddr,
    output logic                  wb_wen,
    output logic                  misalign
);

    lsu_state_e state_r, state_next;
    logic       is_load_r;
    logic [2:0] funct3_r;
    logic [1:0] offset_r;
    logic       accept_s, mem_op_s, trap_s;
    logic [2:0] fmt_funct3_s;
    logic [1:0] fmt_offset_s;
    logic [DATA_WIDTH-1:0] fmt_ldata_s, fmt_wdata_s;
    logic [3:0] fmt_wmask_s;

    assign accept_s = (state_r == ST_IDLE) && in_valid;
    assign mem_op_s = in_is_load | in_is_store;

`ifdef YSYX_25030093_LSU_MISALIGN_TRAP_EN
    assign trap_s = mem_op_s & is_misaligned(in_funct3, in_addr[1:0]);
`else
    assign trap_s = 1'b0;
`endif

    // The formatter sees live inputs while accepting stores, latched fields while loading.
    assign fmt_funct3_s = (state_r == ST_IDLE) ? in_funct3    : funct3_r;
    assign fmt_offset_s = (state_r == ST_IDLE) ? in_addr[1:0] : offset_r;

    ysyx_25030093_lsu_fmt #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
        .funct3 (fmt_funct3_s),
        .offset (fmt_offset_s),
        .sdata  (in_sdata),
        .rdata  (mem_rsp_rdata),
        .ldata  (fmt_ldata_s),
        .wdata  (fmt_wdata_s),
        .wmask  (fmt_wmask_s)
    );

    // Next-state selection.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    if (mem_op_s && !trap_s) begin
                        state_next = ST_REQ;
                    end else begin
                        state_next = ST_WB;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_next = ST_RESP;
                end else begin
                    state_next = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem_rsp_valid) begin
                    state_next = ST_WB;
                end else begin
                    state_next = ST_RESP;
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_WB;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, latched instruction fields and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            is_load_r     <= 1'b0;
            funct3_r      <= 3'b000;
            offset_r      <= 2'b00;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= 4'b0000;
            wb_valid      <= 1'b0;
            wb_wdata      <= '0;
            wb_waddr      <= '0;
            wb_wen        <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            state_r       <= state_next;
            in_ready      <= (state_next == ST_IDLE);
            mem_req_valid <= (state_next == ST_REQ);
            wb_valid      <= (state_next == ST_WB);
            misalign      <= accept_s & trap_s;
            if (accept_s) begin
                is_load_r <= in_is_load;
                funct3_r  <= in_funct3;
                offset_r  <= in_addr[1:0];
                wb_waddr  <= in_rd;
                wb_wen    <= in_wen & ~in_is_store & (in_rd != '0) & ~trap_s;
                wb_wdata  <= mem_op_s ? '0 : in_addr;
                if (mem_op_s && !trap_s) begin
                    mem_req_wen   <= in_is_store;
                    mem_req_addr  <= {in_addr[DATA_WIDTH-1:2], 2'b00};
                    mem_req_wdata <= in_is_store ? fmt_wdata_s : '0;
                    mem_req_wmask <= in_is_store ? fmt_wmask_s : 4'b0000;
                end else begin
                    mem_req_wen   <= mem_req_wen;
                    mem_req_addr  <= mem_req_addr;
                    mem_req_wdata <= mem_req_wdata;
                    mem_req_wmask <= mem_req_wmask;
                end
            end else if ((state_r == ST_RESP) && mem_rsp_valid && is_load_r) begin
                wb_wdata <= fmt_ldata_s;
            end else begin
                wb_wdata <= wb_wdata;
            end
        end
    end

endmodule

// File: doc/ysyx_25030093_lsu.md
# ysyx_25030093_lsu

Load/store unit between the execute stage and write-back. It accepts one instruction at a time from the execute stage and drives a single-outstanding request/response memory bus for loads and stores. It formats load data (sign/zero extension, byte lane select) and hands the GPR write-back packet (`wdata`/`waddr`/`wen`) to the write-back unit over a valid/ready handshake. Non-memory instructions pass straight through.

## Interface
Parameters:
- ADDR_WIDTH, 5, GPR index width
- DATA_WIDTH, 32, data/address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  execute stage has an instruction
- in_ready  out  1  LSU can accept (high only in IDLE)
- in_is_load / in_is_store  in  1 each  memory op type (both 0 = pass-through)
- in_funct3  in  3  RV32 width/sign code
- in_addr  in  DATA_WIDTH  ALU result: effective address, or pass-through result
- in_sdata  in  DATA_WIDTH  store data (rs2)
- in_rd  in  ADDR_WIDTH  destination register
- in_wen  in  1  GPR write enable
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_req_wen  out  1  1 = store
- mem_req_addr  out  DATA_WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata  out  DATA_WIDTH  store data shifted into byte lanes
- mem_req_wmask  out  4  byte strobes
- mem_rsp_valid  in  1  response (load data or store ack)
- mem_rsp_rdata  in  DATA_WIDTH  raw read word
- wb_valid  out  1  write-back packet valid
- wb_ready  in  1  write-back unit accepts
- wb_wdata  out  DATA_WIDTH  GPR write data
- wb_waddr  out  ADDR_WIDTH  GPR index
- wb_wen  out  1  GPR write enable (forced 0 for stores and rd==0)
- misalign  out  1  one-cycle pulse on misaligned access (macro-dependent)

## Operation
- States: IDLE, REQ, RESP, WB.
- IDLE: in_ready=1. On in_valid, latch all inputs. If memory op, go to REQ; otherwise load wb_wdata=in_addr and go to WB.
- REQ: mem_req_valid=1 with fields held stable. On mem_req_ready, go to RESP. The LSU never retracts a request.
- RESP: wait for mem_rsp_valid. For a load, capture the formatted data; for a store, wdata is don't-care. Then go to WB.
- WB: wb_valid=1 and fields held stable. On wb_ready, go to IDLE.
- Load formatting, with byte offset o=addr[1:0]:
  - funct3 000 LB: sign-extend byte o
  - 100 LBU: zero-extend byte o
  - 001 LH: sign-extend halfword o[1]
  - 101 LHU: zero-extend halfword o[1]
  - 010 LW: full word
- Store lanes:
  - SB: wmask=4'b0001<<o, wdata=sdata[7:0] replicated
  - SH: wmask=4'b0011<<o, wdata=sdata[15:0] replicated
  - SW: wmask=4'b1111
- wb_wen = latched wen & ~is_store & (rd != 0).
- Unused funct3 values are treated as LW/SW.
- A mem_rsp_valid seen outside RESP is ignored.

## Timing
- Reset values: state IDLE, in_ready=1, mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0, wb_valid=0, wb_wdata=0, wb_waddr=0, wb_wen=0, misalign=0.
- Pass-through latency: in_valid accepted at edge N, wb_valid high after edge N+1.
- Memory op, zero-wait bus: accept at N, request at N+1, response at N+2, wb_valid at N+3.
- All outputs are registered.
- rst mid-transaction aborts immediately to IDLE. An in-flight bus response after reset is ignored.

## Configuration
- YSYX_25030093_LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access (halfword with o[0]=1, word with o≠0) skips REQ/RESP and goes directly to WB with wb_wen=0.
  - misalign pulses for one cycle on entry to WB.
- Not defined: misalign is tied to 0. Misaligned offsets use the lane rules above (word ops ignore o); no trap.

## Structure
- Shared package:
  - state encoding enum
  - funct3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW)
  - mask constants
- One sub-module, ysyx_25030093_lsu_fmt: combinational load extractor and store lane/mask generator, reused by both directions.

## Test plan
- Pass-through: in_addr=0x1234, rd=5, wen=1 -> wb_wdata=0x1234, wb_waddr=5, wb_wen=1 one cycle after accept.
- LB at addr 0x80000003, rdata=0x80FF0000 -> wb_wdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at addr 0x102, sdata=0xABCD1234 -> mem_req_addr=0x100, wmask=0b1100, wdata[31:16]=0x1234, wb_wen=0.
- Backpressure: mem_req_ready low 3 cycles and wb_ready low 2 cycles -> request and wb fields stay stable, in_ready=0 throughout, exactly one write-back.
- Async reset asserted in RESP -> all outputs go to reset values without a clock edge. A later mem_rsp_valid produces no wb_valid.
- Macro on: LW at 0x102 -> no mem_req_valid, misalign pulse, wb_wen=0. Macro off: the same LW is issued to 0x100.
